// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous flush and optional FWFT read.
`timescale 1ns/1ps
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             w_EN,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_EN,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_acc, wr_acc;
  logic [WIDTH-1:0] head;

  assign full         = (count_q == PW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= PW'(AF_LEVEL));
  assign almost_empty = (count_q <= PW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A read on a full FIFO frees the slot the same-edge write needs.
  assign rd_acc = r_EN && !empty;
  assign wr_acc = w_EN && (!full || rd_acc);
  assign head   = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
      if (w_EN && !wr_acc) ovf_d = 1'b1;
      if (r_EN && empty)   udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left unreset; flush drops the same-cycle write.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wptr_q[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : head;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (clr)         dout_d = '0;
        else if (rd_acc) dout_d = head;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed scoreboard bench for fifo_param: registered-read instance checked through an
// expected-data queue, plus a first-word-fall-through instance checked directly.
`timescale 1ns/1ps
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr0 = 0, w0 = 0, r0 = 0;
  logic [7:0] din0 = 0;
  logic [7:0] dout0;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0] cnt0;
  logic       clr1 = 0, w1 = 0, r1 = 0;
  logic [7:0] din1 = 0;
  logic [7:0] dout1;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic rd_pend = 1'b0;

  always #5 clk = ~clk;

  fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .w_EN(w0), .data_in(din0), .r_EN(r0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .w_EN(w1), .data_in(din1), .r_EN(r1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Registered read: the popped word is on data_out the cycle after the accepting edge.
  always @(posedge clk) rd_pend <= r0 && !empty0 && !clr0;

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no output", dout0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout0 !== e) begin
          failures++;
          $display("FAIL sb_data: got %0h expected %0h", dout0, e);
        end
      end
    end
  end

  task automatic wr0(input logic [7:0] d);
    w0 = 1; din0 = d; cyc(); w0 = 0;
  endtask

  task automatic rd0(input logic [7:0] e);
    exp_q.push_back(e); r0 = 1; cyc(); r0 = 0;
  endtask

  initial begin
    // 1. reset and basic order
    #12;
    check("rst_count", cnt0, 0);
    check("rst_empty", empty0, 1);
    check("rst_ae", ae0, 1);
    check("rst_full", full0, 0);
    check("rst_af", af0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_udf", udf0, 0);
    check("rst_dout", dout0, 0);
    check("rst_dout_fwft", dout1, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 1; i <= 4; i++) begin
      wr0(8'(i));
      check("s1_wcount", cnt0, i);
    end
    for (int i = 1; i <= 4; i++) begin
      rd0(8'(i));
      check("s1_rcount", cnt0, 4 - i);
    end
    cyc();
    check("s1_empty", empty0, 1);
    check("s1_ovf", ovf0, 0);
    check("s1_udf", udf0, 0);

    // 2. fill and overflow
    for (int i = 0; i < 8; i++) begin
      wr0(8'h10 + 8'(i));
      check("s2_count", cnt0, i + 1);
      check("s2_af", af0, (i + 1 >= 6) ? 1 : 0);
      check("s2_full", full0, (i == 7) ? 1 : 0);
    end
    wr0(8'h18);
    check("s2_ovf", ovf0, 1);
    check("s2_count_held", cnt0, 8);
    for (int i = 0; i < 8; i++) rd0(8'h10 + 8'(i));
    cyc();
    check("s2_drained", empty0, 1);
    check("s2_ovf_sticky", ovf0, 1);

    // 3. empty read and simultaneous operations
    clr0 = 1; cyc(); clr0 = 0;
    check("s3_clr_ovf", ovf0, 0);
    r0 = 1; cyc(); r0 = 0;
    check("s3_udf", udf0, 1);
    check("s3_udf_count", cnt0, 0);
    w0 = 1; r0 = 1; din0 = 8'hAA; cyc(); w0 = 0; r0 = 0;
    check("s3_wr_empty_count", cnt0, 1);
    for (int i = 1; i <= 7; i++) wr0(8'hB0 + 8'(i));
    check("s3_full", full0, 1);
    exp_q.push_back(8'hAA);
    w0 = 1; r0 = 1; din0 = 8'hC0; cyc(); w0 = 0; r0 = 0;
    check("s3_full_rw_count", cnt0, 8);
    check("s3_full_rw_ovf", ovf0, 0);
    for (int i = 1; i <= 7; i++) rd0(8'hB0 + 8'(i));
    rd0(8'hC0);
    cyc();
    check("s3_empty", empty0, 1);

    // 4. wrap-around at count 3
    for (int i = 0; i < 3; i++) wr0(8'(i));
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'(i));
      w0 = 1; r0 = 1; din0 = 8'(i + 3); cyc();
      check("s4_count", cnt0, 3);
      check("s4_flags", {full0, empty0, af0, ae0, ovf0}, 5'b00000);
    end
    w0 = 0; r0 = 0;
    for (int i = 20; i < 23; i++) rd0(8'(i));
    cyc();
    check("s4_empty", empty0, 1);

    // 5. clr and asynchronous reset mid-stream
    for (int i = 0; i < 9; i++) wr0(8'h30 + 8'(i));
    for (int i = 0; i < 3; i++) rd0(8'h30 + 8'(i));
    check("s5_pre_count", cnt0, 5);
    check("s5_pre_ovf", ovf0, 1);
    clr0 = 1; w0 = 1; din0 = 8'hEE; cyc(); clr0 = 0; w0 = 0;
    check("s5_clr_count", cnt0, 0);
    check("s5_clr_empty", empty0, 1);
    check("s5_clr_ovf", ovf0, 0);
    check("s5_clr_dout", dout0, 0);
    for (int i = 1; i <= 3; i++) wr0(8'h40 + 8'(i));
    check("s5_refill", cnt0, 3);
    #2 rst_n = 0;
    #1;
    check("s5_arst_count", cnt0, 0);
    check("s5_arst_empty", empty0, 1);
    @(negedge clk); rst_n = 1;
    rd0(8'h41);
    check("s5_after_rst_udf", udf0, 1);

    // 6. first-word-fall-through
    w1 = 1; din1 = 8'h55; cyc(); w1 = 0;
    check("s6_fall", dout1, 8'h55);
    check("s6_count", cnt1, 1);
    w1 = 1; din1 = 8'h66; cyc(); w1 = 0;
    check("s6_head_hold", dout1, 8'h55);
    r1 = 1; cyc(); r1 = 0;
    check("s6_pop1", dout1, 8'h66);
    r1 = 1; cyc(); r1 = 0;
    check("s6_empty", empty1, 1);
    check("s6_zero", dout1, 0);

    // s5 queued a read against the reset FIFO; it was rejected, so drop that entry.
    if (exp_q.size() == 1) void'(exp_q.pop_front());
    check("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
